range_scaler: RTL and testbench

Parametrised linear range scaler. It maps an unsigned input from [g_OLD_MIN, g_OLD_MAX] onto [g_NEW_MIN, g_NEW_MAX] using the formula out = (clamp(x) − g_OLD_MIN)·(g_NEW_MAX − g_NEW_MIN)/(g_OLD_MAX − g_OLD_MIN) + g_NEW_MIN. Input and output widths are generic, and out-of-range inputs are clamped and flagged. The block contains its own sequential restoring divider and uses valid/ready handshakes on both sides. It sits between sensor/ADC sample sources and display or PWM consumers wherever a value must be rescaled.

---
 rtl/range_scaler.sv | 149 ++++++++++++++
 tb/tb_range_scaler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/range_scaler.sv
// Linear range scaler: clamp, multiply by the new span, then divide by the old span
// with a bit-serial restoring divider. Define RANGE_SCALER_ROUND_EN for round-to-nearest.
module range_scaler #(
    parameter int unsigned g_IN_WIDTH  = 8,
    parameter int unsigned g_OUT_WIDTH = 4,
    parameter int unsigned g_OLD_MIN   = 10,
    parameter int unsigned g_OLD_MAX   = 100,
    parameter int unsigned g_NEW_MIN   = 0,
    parameter int unsigned g_NEW_MAX   = 15
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Valid,
    output logic                   o_Ready,
    input  logic [g_IN_WIDTH-1:0]  i_Data,
    output logic                   o_Valid,
    input  logic                   i_Ready,
    output logic [g_OUT_WIDTH-1:0] o_Data,
    output logic                   o_Clamped
);

    localparam int unsigned P  = g_IN_WIDTH + g_OUT_WIDTH;
    localparam int unsigned CW = $clog2(P + 1);

    localparam logic [g_IN_WIDTH-1:0]  OLD_MIN_W = g_IN_WIDTH'(g_OLD_MIN);
    localparam logic [g_IN_WIDTH-1:0]  OLD_MAX_W = g_IN_WIDTH'(g_OLD_MAX);
    localparam logic [g_OUT_WIDTH-1:0] NEW_MIN_N = g_OUT_WIDTH'(g_NEW_MIN);
    localparam logic [P-1:0]           NR_P      = P'(g_NEW_MAX - g_NEW_MIN);
    localparam logic [P:0]             OR_E      = (P + 1)'(g_OLD_MAX - g_OLD_MIN);
`ifdef RANGE_SCALER_ROUND_EN
    localparam logic [P-1:0]           HALF_P    = P'((g_OLD_MAX - g_OLD_MIN) / 2);
`endif

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [g_IN_WIDTH-1:0]  x_q, x_d;
    logic                   clamp_q, clamp_d;
    logic [P-1:0]           num_q, num_d;
    logic [P-1:0]           rem_q, rem_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [g_OUT_WIDTH-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   clamped_q, clamped_d;

    logic [g_IN_WIDTH-1:0]  diff;
    logic [P:0]             rem_ext;

    assign diff    = x_q - OLD_MIN_W;
    // Remainder shifted left with the next numerator bit; one extra bit avoids overflow.
    assign rem_ext = {rem_q, num_q[P-1]};

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        clamp_d   = clamp_q;
        num_d     = num_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        clamped_d = clamped_q;
        unique case (state_q)
            StIdle: begin
                if (i_Valid) begin
                    if (i_Data < OLD_MIN_W) begin
                        x_d     = OLD_MIN_W;
                        clamp_d = 1'b1;
                    end else if (i_Data > OLD_MAX_W) begin
                        x_d     = OLD_MAX_W;
                        clamp_d = 1'b1;
                    end else begin
                        x_d     = i_Data;
                        clamp_d = 1'b0;
                    end
                    state_d = StMul;
                end
            end
            StMul: begin
`ifdef RANGE_SCALER_ROUND_EN
                num_d = P'(diff) * NR_P + HALF_P;
`else
                num_d = P'(diff) * NR_P;
`endif
                rem_d   = '0;
                cnt_d   = CW'(P);
                state_d = StDiv;
            end
            StDiv: begin
                if (cnt_q == '0) begin
                    data_d    = num_q[g_OUT_WIDTH-1:0] + NEW_MIN_N;
                    valid_d   = 1'b1;
                    clamped_d = clamp_q;
                    state_d   = StDone;
                end else begin
                    // Quotient bits shift into num_q as numerator bits shift out.
                    if (rem_ext >= OR_E) begin
                        rem_d = P'(rem_ext - OR_E);
                        num_d = {num_q[P-2:0], 1'b1};
                    end else begin
                        rem_d = rem_ext[P-1:0];
                        num_d = {num_q[P-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StDone: begin
                if (i_Ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            clamp_q   <= 1'b0;
            num_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            clamp_q   <= clamp_d;
            num_q     <= num_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            clamped_q <= clamped_d;
        end
    end

    assign o_Ready   = (state_q == StIdle) && !i_Rst;
    assign o_Valid   = valid_q;
    assign o_Data    = data_q;
    assign o_Clamped = clamped_q;

endmodule

// File: tb/tb_range_scaler.sv
// Directed bench for range_scaler with default parameters; expected values are
// hand-computed from the scaling formula (rounded variant under RANGE_SCALER_ROUND_EN).
module tb_range_scaler;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_Valid;
    logic       o_Ready;
    logic [7:0] i_Data;
    logic       o_Valid;
    logic       i_Ready;
    logic [3:0] o_Data;
    logic       o_Clamped;

    int checks = 0;
    int errors = 0;

    range_scaler dut (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Valid   (i_Valid),
        .o_Ready   (o_Ready),
        .i_Data    (i_Data),
        .o_Valid   (o_Valid),
        .i_Ready   (i_Ready),
        .o_Data    (o_Data),
        .o_Clamped (o_Clamped)
    );

    always #5 i_Clk = ~i_Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Present one sample, then wait (bounded) for o_Valid, optionally wiggling the inputs.
    task automatic launch(input logic [7:0] data, input bit wiggle, output int lat);
        i_Valid = 1'b1;
        i_Data  = data;
        check("ready_before_accept", 32'(o_Ready), 32'd1);
        tick();
        i_Valid = 1'b0;
        i_Data  = 8'd0;
        lat = 0;
        while (!o_Valid && lat < 40) begin
            if (wiggle) begin
                i_Valid = 1'($urandom);
                i_Data  = 8'($urandom);
            end
            tick();
            lat++;
        end
        i_Valid = 1'b0;
        check("valid_seen", 32'(o_Valid), 32'd1);
    endtask

    task automatic run_sample(input string tag, input logic [7:0] data, input logic [3:0] exp_d,
                              input logic exp_c, input bit wiggle);
        int lat;
        launch(data, wiggle, lat);
        check({tag, "_latency"}, 32'(lat), 32'd14);
        check({tag, "_data"}, 32'(o_Data), 32'(exp_d));
        check({tag, "_clamped"}, 32'(o_Clamped), 32'(exp_c));
        check({tag, "_ready_in_done"}, 32'(o_Ready), 32'd0);
        tick();
        check({tag, "_valid_cleared"}, 32'(o_Valid), 32'd0);
        check({tag, "_ready_after"}, 32'(o_Ready), 32'd1);
    endtask

    initial begin
        int lat;
        bit saw_valid;
        i_Rst   = 1'b1;
        i_Valid = 1'b0;
        i_Data  = 8'd0;
        i_Ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(o_Valid), 32'd0);
        check("rst_data", 32'(o_Data), 32'd0);
        check("rst_clamped", 32'(o_Clamped), 32'd0);
        check("rst_ready", 32'(o_Ready), 32'd0);
        i_Rst = 1'b0;
        #1;
        check("ready_after_release", 32'(o_Ready), 32'd1);

`ifdef RANGE_SCALER_ROUND_EN
        run_sample("mid55", 8'd55, 4'd8, 1'b0, 1'b0);
`else
        run_sample("mid55", 8'd55, 4'd7, 1'b0, 1'b0);
`endif
        run_sample("min10", 8'd10, 4'd0, 1'b0, 1'b0);
        run_sample("max100", 8'd100, 4'd15, 1'b0, 1'b0);
        run_sample("clamp5", 8'd5, 4'd0, 1'b1, 1'b0);
        run_sample("clamp200", 8'd200, 4'd15, 1'b1, 1'b0);

        // Backpressure: 30*15/90 = 5 in both builds.
        i_Ready = 1'b0;
        launch(8'd40, 1'b0, lat);
        check("bp_latency", 32'(lat), 32'd14);
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", 32'(o_Valid), 32'd1);
            check("bp_data", 32'(o_Data), 32'd5);
            check("bp_ready", 32'(o_Ready), 32'd0);
            tick();
        end
        i_Ready = 1'b1;
        tick();
        i_Ready = 1'b0;
        check("bp_ready_after", 32'(o_Ready), 32'd1);
        check("bp_valid_after", 32'(o_Valid), 32'd0);
        check("bp_data_held", 32'(o_Data), 32'd5);
        i_Ready = 1'b1;

        // Reset six cycles after accepting 90.
        i_Valid = 1'b1;
        i_Data  = 8'd90;
        tick();
        i_Valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        #1;
        check("mrst_valid", 32'(o_Valid), 32'd0);
        check("mrst_data", 32'(o_Data), 32'd0);
        check("mrst_clamped", 32'(o_Clamped), 32'd0);
        check("mrst_ready", 32'(o_Ready), 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_Valid) saw_valid = 1'b1;
        end
        check("mrst_no_valid", 32'(saw_valid), 32'd0);
        run_sample("post_rst100", 8'd100, 4'd15, 1'b0, 1'b0);

        // Inputs toggled during MUL/DIV must not disturb the accepted 55.
`ifdef RANGE_SCALER_ROUND_EN
        run_sample("ignore55", 8'd55, 4'd8, 1'b0, 1'b1);
`else
        run_sample("ignore55", 8'd55, 4'd7, 1'b0, 1'b1);
`endif
        run_sample("ignore_clamp3", 8'd3, 4'd0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
